// File: rtl/pipe_pkg.sv
// Shared constants and entry-state type for the pipeline stage register.
// Used by pipe_stage_reg and sat_counter.
package pipe_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   function automatic logic [1:0] live_cnt(state_e s);
      logic [1:0] n;
      case (s)
         ONE:     n = 2'd1;
         TWO:     n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, adds 0..2 per falling edge, sticks at all-ones.
// Synchronous active-high reset.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum;

   assign sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc_i};

   always_comb begin
      cnt_d = sum[CNT_W-1:0];
      if (sum[CNT_W]) cnt_d = '1;
   end

   always_ff @(negedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush and drop counter, falling-edge clocked.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  drop_cnt
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              in_xfer, out_xfer;
   logic [1:0]        drop_inc;

`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              rdy_q, rdy_d;

   assign in_ready = rdy_q;
   assign rdy_d    = (state_d != TWO);
`else
   assign in_ready = !out_valid || out_ready;
`endif

   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_valid ? head_q : '0;
   assign in_xfer   = in_valid && in_ready && !flush;
   assign out_xfer  = out_valid && out_ready && !flush;

   always_comb begin
      state_d  = state_q;
      head_d   = head_q;
      drop_inc = 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      skid_d   = skid_q;
`endif
      if (flush) begin
         state_d  = EMPTY;
         head_d   = '0;
         drop_inc = live_cnt(state_q);
`ifdef PIPE_STAGE_SKID_EN
         skid_d   = '0;
`endif
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  state_d = ONE;
                  head_d  = in_data;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  head_d = in_data;
               end else if (out_xfer) begin
                  state_d = EMPTY;
                  head_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
               end else if (in_xfer) begin
                  state_d = TWO;
                  skid_d  = in_data;
`endif
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            // Full: in_ready is low, so only the head can leave.
            TWO: begin
               if (out_xfer) begin
                  state_d = ONE;
                  head_d  = skid_q;
                  skid_d  = '0;
               end
            end
`endif
            default: begin
               state_d = EMPTY;
               head_d  = '0;
            end
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_q  <= '0;
         rdy_q   <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
`ifdef PIPE_STAGE_SKID_EN
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
`endif
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_drop (
      .clk   (clk),
      .reset (reset),
      .inc_i (drop_inc),
      .cnt_o (drop_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue model checked every cycle plus directed literals.
// Covers both builds; skid-only vectors appear when PIPE_STAGE_SKID_EN is set.
module tb_pipe_stage_reg;

   localparam int DW = 64;
   localparam int CW = 4;
   localparam int CMAX = 15;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk = 1'b1;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] drop_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] mq[$];
   int            mdrop = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W(DW),
      .CNT_W (CW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .drop_cnt (drop_cnt)
   );

   task automatic chk(input string name, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic bit model_rdy();
      if (SKID) return mq.size() < 2;
      return mq.size() == 0 || out_ready;
   endfunction

   // Model: a bounded FIFO of depth 1 (or 2 with skid) updated on the falling edge.
   always @(negedge clk) begin : mdl
      bit rdy;
      rdy = model_rdy();
      if (reset) begin
         mq.delete();
         mdrop = 0;
      end else if (flush) begin
         mdrop = mdrop + mq.size();
         if (mdrop > CMAX) mdrop = CMAX;
         mq.delete();
      end else begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (in_valid && rdy) mq.push_back(in_data);
      end
   end

   always @(posedge clk) begin
      if (chk_en) begin
         chk("m_out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
         chk("m_out_data", out_data, (mq.size() > 0) ? mq[0] : '0);
         chk("m_drop_cnt", {60'd0, drop_cnt}, DW'(mdrop));
         chk("m_in_ready", {63'd0, in_ready}, {63'd0, model_rdy()});
      end
   end

   task automatic drive(input bit rst, input bit v, input logic [DW-1:0] d,
                        input bit fl, input bit ordy);
      reset     = rst;
      in_valid  = v;
      in_data   = d;
      flush     = fl;
      out_ready = ordy;
      @(negedge clk);
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0);
      drive(1, 1, 64'h55, 1, 1);
      drive(0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_drop", {60'd0, drop_cnt}, 64'd0);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);

      drive(0, 1, 64'hA5, 0, 1);
      chk("a5_valid", {63'd0, out_valid}, 64'd1);
      chk("a5_data", out_data, 64'hA5);

      for (int i = 1; i <= 3; i++) begin
         drive(0, 1, DW'(i), 0, 1);
         chk("stream_data", out_data, DW'(i));
         chk("stream_valid", {63'd0, out_valid}, 64'd1);
      end
      drive(0, 0, 0, 0, 1);
      chk("drain_valid", {63'd0, out_valid}, 64'd0);
      chk("drain_data", out_data, 64'd0);

      drive(0, 1, 64'd0, 0, 0);
      chk("zero_valid", {63'd0, out_valid}, 64'd1);
      chk("zero_data", out_data, 64'd0);
      drive(0, 1, 64'hDEAD, 1, 1);
      chk("fl1_valid", {63'd0, out_valid}, 64'd0);
      chk("fl1_data", out_data, 64'd0);
      chk("fl1_drop", {60'd0, drop_cnt}, 64'd1);

`ifdef PIPE_STAGE_SKID_EN
      drive(0, 1, 64'h10, 0, 0);
      drive(0, 1, 64'h20, 0, 0);
      chk("skid_ready", {63'd0, in_ready}, 64'd0);
      chk("skid_head", out_data, 64'h10);
      drive(0, 0, 0, 0, 1);
      chk("skid_second", out_data, 64'h20);
      drive(0, 0, 0, 0, 1);
      chk("skid_empty", {63'd0, out_valid}, 64'd0);
      drive(0, 1, 64'h30, 0, 0);
      drive(0, 1, 64'h40, 0, 0);
      drive(0, 1, 64'h50, 1, 1);
      chk("fl2_valid", {63'd0, out_valid}, 64'd0);
      chk("fl2_data", out_data, 64'd0);
      chk("fl2_drop", {60'd0, drop_cnt}, 64'd3);
      chk("fl2_ready", {63'd0, in_ready}, 64'd1);
`endif

      for (int i = 0; i < 24; i++) begin
         drive(0, (i % 3) != 2, DW'(i * 'h11 + 1), 0, (i % 4) != 1);
      end
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);

      for (int k = 0; k < 20; k++) begin
         drive(0, 1, DW'(k + 'h100), 0, 0);
         drive(0, 0, 0, 1, 0);
      end
      chk("sat_drop", {60'd0, drop_cnt}, 64'd15);
      drive(0, 1, 64'h77, 0, 0);
      drive(0, 0, 0, 1, 0);
      chk("sat_hold", {60'd0, drop_cnt}, 64'd15);

      drive(0, 1, 64'h99, 0, 0);
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      drive(1, 1, 64'hBB, 1, 1);
      chk("rf_valid", {63'd0, out_valid}, 64'd0);
      chk("rf_data", out_data, 64'd0);
      chk("rf_drop", {60'd0, drop_cnt}, 64'd0);
      drive(0, 0, 0, 0, 0);
      chk("rf_ready", {63'd0, in_ready}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, default 64, payload width in bits (instruction + PC for the fetch/decode stage).
REQ-002 Parameter: CNT_W, default 16, width of the flush-drop counter.
REQ-003 clk  input  1  stage clock; all state updates on falling edge (pipeline-register convention).
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  stage accepts in_data this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 flush  input  1  discard all held entries (branch taken / IF flush).
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle (hazard-unit write enable).
REQ-011 out_data  output  DATA_W  oldest held payload.
REQ-012 drop_cnt  output  CNT_W  count of live entries discarded by flush.

Function
REQ-013 Input transfer SHALL occur on a falling edge when in_valid && in_ready && !flush.
REQ-014 Output transfer SHALL occur on a falling edge when out_valid && out_ready && !flush.
REQ-015 Ordering SHALL be strict FIFO; no payload is duplicated or lost except by flush.
REQ-016 out_data SHALL be all-zero whenever out_valid=0 (bubble is a zero word).
REQ-017 Latency SHALL be one edge: data accepted at edge N appears on out_data after edge N when the stage was empty.
REQ-018 Flush SHALL clear every entry at the edge, zero out_data, and ignore any coincident input or output transfer.
REQ-019 Flush SHALL add the number of live entries (0, 1 or 2) to drop_cnt, saturating at all-ones.
REQ-020 Simultaneous input and output transfer on a full single entry SHALL replace the entry (full throughput, no bubble).
REQ-021 in_ready SHALL be combinational in single-entry mode: in_ready = !out_valid || out_ready.
REQ-022 in_valid with in_data=0 SHALL still be a valid transfer (validity is explicit, never inferred from data).

Reset
REQ-023 reset SHALL take priority over flush and all transfers.
REQ-024 After reset: out_valid=0, out_data=0, drop_cnt=0, all entries empty; in_ready=1.
REQ-025 Reset mid-transfer SHALL discard in-flight data without incrementing drop_cnt.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN SHALL add a second (skid) entry.
REQ-027 With PIPE_STAGE_SKID_EN: in_ready SHALL be registered, = !(both entries full), with no combinational path from out_ready.
REQ-028 With PIPE_STAGE_SKID_EN: an input accepted while the head is stalled SHALL go to the skid entry and move to head on the next output transfer.
REQ-029 Without PIPE_STAGE_SKID_EN: single entry only; behaviour per REQ-021.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the default DATA_W/CNT_W constants and the entry-state enum (EMPTY, ONE, TWO).
REQ-031 The saturating counter SHALL be a sub-module sat_counter (CNT_W, increment 0..2).
REQ-032 State machine: EMPTY->ONE on input; ONE->TWO on input without output (skid only); TWO->ONE on output; any->EMPTY on flush/reset.

Verification
REQ-033 Reset then in_valid=1, in_data=0xA5, out_ready=1 -> next edge out_valid=1, out_data=0xA5.
REQ-034 Stream 0x1,0x2,0x3 with out_ready=1 every cycle -> outputs 0x1,0x2,0x3 on consecutive edges, no bubble.
REQ-035 Skid build: out_ready=0, push 0x10, 0x20 -> in_ready=0 after second edge; out_ready=1 -> 0x10 then 0x20.
REQ-036 Two entries held, flush=1 with in_valid=1 -> out_valid=0, out_data=0, drop_cnt=2, input ignored.
REQ-037 drop_cnt at all-ones, flush with one entry -> drop_cnt stays all-ones.
REQ-038 reset and flush asserted together with one entry -> all outputs at reset values, drop_cnt=0.
